// File: rtl/sigmoid_grad_unit.sv
// Sigmoid backward delta g*s*(1-s) on one shared multiplier; 3 cycles accept-to-out_valid.
// Accepts one sample at a time: in_ready low from accept until the result is taken, out_valid held under backpressure.
module sigmoid_grad_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int GRAD_FRAC  = 4,
  parameter int ACT_FRAC   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [2*DATA_WIDTH-1:0] act_in,
  input  logic signed [DATA_WIDTH-1:0]   grad_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [2*DATA_WIDTH-1:0] delta_out,
  output logic                          sat_flag,
  output logic                          clamp_flag
);

  localparam int AW = 2 * DATA_WIDTH;
  localparam int MW = AW + 1;
  localparam int PW = 2 * MW;

  localparam logic signed [MW-1:0] ONE      = MW'(1) << ACT_FRAC;
  localparam logic signed [PW-1:0] RND_ACT  = PW'(1) << (ACT_FRAC - 1);
  localparam logic signed [PW-1:0] RND_GRAD = PW'(1) << (GRAD_FRAC - 1);
  localparam logic signed [PW-1:0] SAT_MAX  = {{(PW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN  = {{(PW-AW+1){1'b1}}, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL1, S_MUL2, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic signed [MW-1:0]   r_a;
  logic signed [DATA_WIDTH-1:0] r_g;
  logic signed [MW-1:0]   r_d;
  logic                   r_clamp;
  logic signed [AW-1:0]   r_delta;
  logic                   r_sat;
  logic                   r_clamp_out;

  logic signed [MW-1:0]   w_act_ext;
  logic signed [MW-1:0]   w_a_clamped;
  logic                   w_clamped;
  logic signed [MW-1:0]   w_mul_a;
  logic signed [MW-1:0]   w_mul_b;
  logic signed [PW-1:0]   w_prod;
  logic signed [MW-1:0]   w_d_nxt;
  logic signed [PW-1:0]   w_rnd_grad;
  logic signed [AW-1:0]   w_sat_val;
  logic                   w_sat;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_MUL1;
      end
      S_MUL1: w_state_nxt = S_MUL2;
      S_MUL2: w_state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Activation is forced into [0, ONE] so a*(ONE-a) never goes negative.
  assign w_act_ext = MW'(act_in);

  always_comb begin
    w_a_clamped = w_act_ext;
    w_clamped   = 1'b0;
    if (act_in[AW-1]) begin
      w_a_clamped = '0;
      w_clamped   = 1'b1;
    end else if (w_act_ext > ONE) begin
      w_a_clamped = ONE;
      w_clamped   = 1'b1;
    end
  end

  always_comb begin
    w_mul_a = r_a;
    w_mul_b = ONE - r_a;
    if (r_state == S_MUL2) begin
      w_mul_a = MW'(r_g);
      w_mul_b = r_d;
    end
  end

  assign w_prod     = PW'(w_mul_a) * PW'(w_mul_b);
  assign w_d_nxt    = MW'((w_prod + RND_ACT) >>> ACT_FRAC);
  assign w_rnd_grad = (w_prod + RND_GRAD) >>> GRAD_FRAC;

  always_comb begin
    w_sat_val = AW'(w_rnd_grad);
    w_sat     = 1'b0;
    if (w_rnd_grad > SAT_MAX) begin
      w_sat_val = {1'b0, {(AW-1){1'b1}}};
      w_sat     = 1'b1;
    end else if (w_rnd_grad < SAT_MIN) begin
      w_sat_val = {1'b1, {(AW-1){1'b0}}};
      w_sat     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_g         <= '0;
      r_d         <= '0;
      r_clamp     <= 1'b0;
      r_delta     <= '0;
      r_sat       <= 1'b0;
      r_clamp_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= w_a_clamped;
            r_g     <= grad_in;
            r_clamp <= w_clamped;
          end
        end
        S_MUL1: r_d <= w_d_nxt;
        S_MUL2: begin
          r_delta     <= w_sat_val;
          r_sat       <= w_sat;
          r_clamp_out <= r_clamp;
        end
        default: ;
      endcase
    end
  end

  assign delta_out  = r_delta;
  assign sat_flag   = r_sat;
  assign clamp_flag = r_clamp_out;

endmodule

// File: tb/tb_sigmoid_grad_unit.sv
// Randomised and directed scoreboard bench for sigmoid_grad_unit against an integer reference model.
module tb_sigmoid_grad_unit;

  localparam longint ONE  = 256;
  localparam longint GSF  = 16;
  localparam longint DMAX = 32767;
  localparam longint DMIN = -32768;

  typedef struct {
    longint delta;
    bit     sat;
    bit     clamp;
    longint acc;
  } exp_t;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [15:0]  act_in;
  logic signed [7:0]   grad_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [15:0]  delta_out;
  logic                sat_flag;
  logic                clamp_flag;

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc = 0;
  bit     prev_ov = 1'b0;
  exp_t   sb[$];

  sigmoid_grad_unit #(.DATA_WIDTH(8), .GRAD_FRAC(4), .ACT_FRAC(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .act_in(act_in), .grad_in(grad_in), .out_valid(out_valid),
    .out_ready(out_ready), .delta_out(delta_out), .sat_flag(sat_flag),
    .clamp_flag(clamp_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic longint fdiv(input longint x, input longint d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  // delta = g * s * (1 - s) in real-number terms, quantised with half-up rounding.
  function automatic exp_t model(input longint act, input longint g);
    exp_t   e;
    longint a, d, r;
    a = act;
    e.clamp = 1'b0;
    if (a < 0) begin a = 0; e.clamp = 1'b1; end
    else if (a > ONE) begin a = ONE; e.clamp = 1'b1; end
    d = fdiv(a * (ONE - a) + ONE / 2, ONE);
    r = fdiv(g * d + GSF / 2, GSF);
    e.sat = 1'b0;
    if (r > DMAX) begin r = DMAX; e.sat = 1'b1; end
    else if (r < DMIN) begin r = DMIN; e.sat = 1'b1; end
    e.delta = r;
    e.acc = 0;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic signed [15:0] a, input logic signed [7:0] g, output longint acc);
    exp_t e;
    int   t;
    act_in   = a;
    grad_in  = g;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    acc = -1;
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
    end else begin
      e = model(a, g);
      acc = cyc + 1;
      e.acc = acc;
      sb.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    longint acc, last_acc, hold_val;
    int     t;
    logic signed [15:0] ra;
    logic signed [7:0]  rg;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; act_in = '0; grad_in = '0;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
          if (out_valid && !prev_ov) begin
            if (sb.size() == 0) chk("out_valid_without_sample", out_valid, 0);
            else chk("latency", cyc - sb[0].acc, 2);
          end
          if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            chk("delta", delta_out, e.delta);
            chk("sat_flag", sat_flag, e.sat);
            chk("clamp_flag", clamp_flag, e.clamp);
          end
        end
        prev_ov = out_valid;
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_delta", delta_out, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_clamp", clamp_flag, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors from hand-computed cases
    send(16'sd128, 8'sd16, acc);  drain();
    send(16'sd64, -8'sd32, acc);  drain();
    send(16'sd200, 8'sd5, acc);   drain();
    send(16'sd0, 8'sd100, acc);   drain();
    send(16'sd256, 8'sd100, acc); drain();
    send(16'sd300, 8'sd100, acc); drain();
    send(-16'sd5, 8'sd100, acc);  drain();
    send(16'sd32767, -8'sd128, acc); drain();

    // Backpressure: result held while out_ready is low, new input ignored
    out_ready = 1'b0;
    send(16'sd100, 8'sd20, acc);
    t = 0;
    while (!out_valid && t < 10) begin @(posedge clk); #1; t++; end
    chk("bp_out_valid", out_valid, 1);
    hold_val = (sb.size() > 0) ? sb[0].delta : 76;
    for (int i = 0; i < 5; i++) begin
      chk("bp_delta_stable", delta_out, hold_val);
      chk("bp_in_ready", in_ready, 0);
      if (i == 1) begin in_valid = 1'b1; act_in = 16'sd128; grad_in = 8'sd16; end
      if (i == 2) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_delta_held", delta_out, 76);
    drain();

    // Back-to-back issue interval
    last_acc = -1;
    for (int i = 0; i < 4; i++) begin
      send(16'(40 + 50 * i), 8'(7 - 5 * i), acc);
      if (i > 0) chk("issue_interval", acc - last_acc, 4);
      last_acc = acc;
    end
    drain();

    // Reset while in MUL1 aborts the sample
    chk("abort_pre_idle", in_ready, 1);
    act_in = 16'sd128; grad_in = 8'sd16; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_in_mul1", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_idle", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_delta", delta_out, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_output", out_valid, 0);
    send(16'sd200, 8'sd5, acc);
    drain();

    // Randomised samples with random downstream stalls
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) ra = 16'($urandom);
      else ra = 16'(int'($urandom_range(0, 320)) - 30);
      rg = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(ra, rg, acc);
      t = 0;
      while (sb.size() > 0 && t < 60) begin
        @(posedge clk); #1;
        out_ready = (t > 30) ? 1'b1 : 1'($urandom_range(0, 1));
        t++;
      end
      chk("rand_complete", sb.size(), 0);
      while (sb.size() > 0) void'(sb.pop_front());
    end
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
